// File: rtl/fir_mac_ctrl.sv
// fir_mac_ctrl: sequencer for a single-MAC FIR filter with an external
// circular sample buffer and an external coefficient ROM.
// Each accepted sample is written to the buffer. Every DECIM-th sample
// then triggers one pass over all TAPS taps. The newest sample is paired
// with coefficient 0. The accumulated sum is shifted right by SHIFT and
// reduced to OUT_WIDTH bits.
// Build option: `define FIR_MAC_SAT_EN saturates the output instead of
// wrapping it.
// Ports:
//   clk, reset         rising-edge clock, synchronous active-low reset
//   x_in, x_strobe     input sample and its one-cycle valid pulse
//   ready              high while a new sample will be accepted
//   cb_wren, cb_rden   circular-buffer write and read enables
//   cb_data_in         sample to the buffer
//   cb_data_out        buffer read data, one cycle after cb_rden
//   coef_addr          ROM address
//   coef_data          ROM data, one cycle after coef_addr
//   y_out, y_strobe    filter output and its one-cycle valid pulse
//   overrun            sticky flag: a sample arrived while busy
module fir_mac_ctrl #(
  parameter int unsigned IN_WIDTH   = 24,
  parameter int unsigned COEF_WIDTH = 18,
  parameter int unsigned TAPS_LOG2  = 8,
  parameter int unsigned ACC_WIDTH  = 50,
  parameter int unsigned SHIFT      = 17,
  parameter int unsigned OUT_WIDTH  = 24,
  parameter int unsigned DECIM      = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [IN_WIDTH-1:0]   x_in,
  input  logic                         x_strobe,
  output logic                         ready,
  output logic                         cb_wren,
  output logic                         cb_rden,
  output logic signed [IN_WIDTH-1:0]   cb_data_in,
  input  logic signed [IN_WIDTH-1:0]   cb_data_out,
  output logic [TAPS_LOG2-1:0]         coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  output logic signed [OUT_WIDTH-1:0]  y_out,
  output logic                         y_strobe,
  output logic                         overrun
);

  localparam int unsigned TAPS   = 1 << TAPS_LOG2;
  localparam int unsigned PROD_W = IN_WIDTH + COEF_WIDTH;
  localparam int unsigned DEC_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [TAPS_LOG2-1:0] LAST_TAP = TAPS_LOG2'(TAPS - 1);
  localparam logic [DEC_W-1:0]     DEC_LAST = DEC_W'(DECIM - 1);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, OUT} state_t;

  state_t                       r_state, w_state_nxt;
  logic                         r_ready, w_ready_nxt;
  logic                         r_cb_wren, w_wren_nxt;
  logic                         r_cb_rden, w_rden_nxt;
  logic signed [IN_WIDTH-1:0]   r_cb_data_in, w_data_in_nxt;
  logic [TAPS_LOG2-1:0]         r_coef_addr, w_addr_nxt;
  logic [DEC_W-1:0]             r_dec, w_dec_nxt;
  logic                         r_y_strobe, w_ystb_nxt;
  logic signed [OUT_WIDTH-1:0]  r_y_out, w_y;
  logic                         r_overrun;

  // Datapath pipeline: buffer/ROM data valid, product, accumulator
  logic                         r_dv, r_dfirst;
  logic                         r_pv, r_pfirst;
  logic signed [PROD_W-1:0]     r_prod;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic signed [ACC_WIDTH-1:0]  w_prod_ext, w_shifted;

  assign ready      = r_ready;
  assign cb_wren    = r_cb_wren;
  assign cb_rden    = r_cb_rden;
  assign cb_data_in = r_cb_data_in;
  assign coef_addr  = r_coef_addr;
  assign y_out      = r_y_out;
  assign y_strobe   = r_y_strobe;
  assign overrun    = r_overrun;

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_wren_nxt    = 1'b0;
    w_rden_nxt    = 1'b0;
    w_data_in_nxt = r_cb_data_in;
    w_addr_nxt    = r_coef_addr;
    w_dec_nxt     = r_dec;
    w_ystb_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        if (x_strobe) begin
          w_data_in_nxt = x_in;
          w_wren_nxt    = 1'b1;
          w_state_nxt   = WRITE;
        end
      end
      WRITE: begin
        if (r_dec == DEC_LAST) begin
          w_dec_nxt   = '0;
          w_rden_nxt  = 1'b1;
          w_addr_nxt  = '0;
          w_state_nxt = READ;
        end else begin
          w_dec_nxt   = r_dec + DEC_W'(1);
          w_state_nxt = IDLE;
        end
      end
      READ: begin
        if (r_coef_addr == LAST_TAP) begin
          w_addr_nxt  = '0;
          w_state_nxt = DRAIN;
        end else begin
          w_addr_nxt  = r_coef_addr + TAPS_LOG2'(1);
          w_rden_nxt  = 1'b1;
        end
      end
      // Leave once the last read data has moved into the product register;
      // the accumulator then holds the final sum during OUT.
      DRAIN: begin
        if (!r_dv) w_state_nxt = OUT;
      end
      OUT: begin
        w_ystb_nxt  = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_ready_nxt = (w_state_nxt == IDLE);
  end

  // Output scaling: arithmetic shift, then saturate or wrap
  assign w_shifted = r_acc >>> SHIFT;
`ifdef FIR_MAC_SAT_EN
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  always_comb begin
    w_y = OUT_WIDTH'(w_shifted);
    if (w_shifted > SAT_MAX)      w_y = OUT_WIDTH'(SAT_MAX);
    else if (w_shifted < SAT_MIN) w_y = OUT_WIDTH'(SAT_MIN);
  end
`else
  assign w_y = OUT_WIDTH'(w_shifted);
`endif

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_cb_wren    <= 1'b0;
      r_cb_rden    <= 1'b0;
      r_cb_data_in <= '0;
      r_coef_addr  <= '0;
      r_dec        <= '0;
      r_y_strobe   <= 1'b0;
      r_y_out      <= '0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ready      <= w_ready_nxt;
      r_cb_wren    <= w_wren_nxt;
      r_cb_rden    <= w_rden_nxt;
      r_cb_data_in <= w_data_in_nxt;
      r_coef_addr  <= w_addr_nxt;
      r_dec        <= w_dec_nxt;
      r_y_strobe   <= w_ystb_nxt;
      if (w_ystb_nxt) r_y_out <= w_y;
      if (x_strobe && (r_state != IDLE)) r_overrun <= 1'b1;
    end
  end

  assign w_prod_ext = ACC_WIDTH'(r_prod);

  // MAC pipeline; the first product of a pass loads the accumulator
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_dv     <= 1'b0;
      r_dfirst <= 1'b0;
      r_pv     <= 1'b0;
      r_pfirst <= 1'b0;
      r_prod   <= '0;
      r_acc    <= '0;
    end else begin
      r_dv     <= r_cb_rden;
      r_dfirst <= r_cb_rden && (r_coef_addr == '0);
      r_pv     <= r_dv;
      r_pfirst <= r_dfirst;
      if (r_dv) r_prod <= PROD_W'(cb_data_out) * PROD_W'(coef_data);
      if (r_pv) r_acc  <= r_pfirst ? w_prod_ext : r_acc + w_prod_ext;
    end
  end

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// tb_fir_mac_ctrl: two 8-tap instances (DECIM=1 and DECIM=4) with
// behavioural circular-buffer and ROM models, checked against a sample
// history / dot-product reference model.
module tb_fir_mac_ctrl;

  localparam int TAPS   = 8;
  localparam int LAT    = TAPS + 5;
  localparam int BUDGET = 20;

  logic clk;
  logic reset;
  logic [1:0][23:0] x_in;
  logic [1:0]       x_strobe;
  logic [1:0]       ready, cb_wren, cb_rden, y_strobe, overrun;
  logic [1:0][23:0] cb_data_in, y_out;
  logic [1:0][2:0]  coef_addr;

  int rom [2][TAPS];
  int hist[2][$];
  int acc_cnt[2];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int x;
    int y;
  } vec_t;
  vec_t tbl[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic signed [23:0] mem [TAPS];
    logic [2:0]         wp, rp;
    logic signed [23:0] dout;
    logic signed [17:0] cdat;

    fir_mac_ctrl #(
      .TAPS_LOG2(3), .SHIFT(0), .DECIM((g == 0) ? 1 : 4)
    ) u_dut (
      .clk(clk), .reset(reset),
      .x_in(x_in[g]), .x_strobe(x_strobe[g]), .ready(ready[g]),
      .cb_wren(cb_wren[g]), .cb_rden(cb_rden[g]),
      .cb_data_in(cb_data_in[g]), .cb_data_out(dout),
      .coef_addr(coef_addr[g]), .coef_data(cdat),
      .y_out(y_out[g]), .y_strobe(y_strobe[g]), .overrun(overrun[g])
    );

    // Circular buffer: reads walk backwards starting at the newest sample
    always @(posedge clk) begin
      if (!reset) begin
        wp   <= '0;
        rp   <= '0;
        dout <= '0;
        for (int i = 0; i < TAPS; i++) mem[i] <= '0;
      end else begin
        if (cb_wren[g]) begin
          mem[wp] <= cb_data_in[g];
          rp      <= wp;
          wp      <= wp + 3'd1;
        end
        if (cb_rden[g]) begin
          dout <= mem[rp];
          rp   <= rp - 3'd1;
        end
      end
    end

    always @(posedge clk) cdat <= 18'(rom[g][coef_addr[g]]);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int dec_of(input int g);
    return (g == 0) ? 1 : 4;
  endfunction

  // Reference: dot product of ROM with the newest TAPS samples
  function automatic longint ref_y(input int g);
    longint acc = 0;
    int n = hist[g].size();
    for (int k = 0; k < TAPS; k++)
      acc += longint'(rom[g][k]) * longint'(hist[g][n-1-k]);
`ifdef FIR_MAC_SAT_EN
    if (acc > 64'sd8388607)  return 64'sd8388607;
    if (acc < -64'sd8388608) return -64'sd8388608;
    return acc;
`else
    return longint'($signed(24'(acc)));
`endif
  endfunction

  task automatic clear_hist();
    for (int g = 0; g < 2; g++) begin
      hist[g].delete();
      for (int k = 0; k < TAPS; k++) hist[g].push_back(0);
      acc_cnt[g] = 0;
    end
  endtask

  // One sample; optional dropped strobe at cycle dup_at, reset at rst_at
  task automatic send(input int g, input int x, input int dup_at,
                      input int rst_at, output longint yv);
    int  ny = 0, n_y = 0, nw = 0, w_at = 0;
    bit  both = 1'b0;
    bit  exp_y;
    longint ey;
    yv = 0;
    check("ready_before", longint'(ready[g]), 1);
    x_in[g]     = 24'(x);
    x_strobe[g] = 1'b1;
    hist[g].push_back(x);
    acc_cnt[g]++;
    exp_y = (rst_at == 0) && ((acc_cnt[g] % dec_of(g)) == 0);
    ey    = ref_y(g);
    for (int n = 1; n <= BUDGET; n++) begin
      @(negedge clk);
      if (cb_wren[g]) begin nw++; w_at = n; end
      if (cb_wren[g] && cb_rden[g]) both = 1'b1;
      if (y_strobe[g]) begin
        ny++;
        n_y = n;
        yv  = longint'($signed(y_out[g]));
      end
      if (rst_at != 0 && n == rst_at + 1) begin
        check("abort_rden", longint'(cb_rden[g]), 0);
        check("abort_overrun", longint'(overrun[g]), 0);
        check("abort_ready", longint'(ready[g]), 1);
      end
      x_strobe[g] = (n == dup_at);
      reset       = !(n == rst_at);
    end
    check("wren_count", nw, 1);
    check("wren_cycle", w_at, 1);
    check("wren_rden_excl", longint'(both), 0);
    check("ystrobe_count", ny, longint'(exp_y));
    if (exp_y) begin
      check("y_latency", n_y, LAT);
      check("y_model", yv, ey);
    end
  endtask

  initial begin
    longint yv;
    tbl[0] = '{1, 1};
    for (int i = 1; i < 8; i++) tbl[i] = '{0, i + 1};
    tbl[8] = '{0, 0};

    reset    = 1'b0;
    x_strobe = '0;
    x_in     = '0;
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < TAPS; k++) rom[g][k] = k + 1;
    clear_hist();
    repeat (3) @(negedge clk);
    check("rst_ready", longint'(ready[0]), 1);
    check("rst_wren", longint'(cb_wren[0]), 0);
    check("rst_rden", longint'(cb_rden[0]), 0);
    check("rst_addr", longint'(coef_addr[0]), 0);
    check("rst_data_in", longint'(cb_data_in[0]), 0);
    check("rst_y_out", longint'(y_out[0]), 0);
    check("rst_ystrobe", longint'(y_strobe[0]), 0);
    check("rst_overrun", longint'(overrun[0]), 0);
    reset = 1'b1;
    @(negedge clk);

    // Impulse response through the vector table
    for (int i = 0; i < 9; i++) begin
      send(0, tbl[i].x, 0, 0, yv);
      check("impulse_tbl", yv, tbl[i].y);
    end

    // Random coefficients and samples against the model
    for (int k = 0; k < TAPS; k++) rom[0][k] = int'($urandom_range(0, 262143)) - 131072;
    for (int i = 0; i < 16; i++)
      send(0, int'($urandom_range(0, 16777215)) - 8388608, 0, 0, yv);

    // Full-scale input: saturates or wraps
    for (int k = 0; k < TAPS; k++) rom[0][k] = 131071;
    for (int i = 0; i < TAPS; i++) send(0, 8388607, 0, 0, yv);
`ifdef FIR_MAC_SAT_EN
    check("fullscale", yv, 8388607);
`else
    check("fullscale", yv, -1048568);
`endif

    // Strobe while busy is dropped and flagged
    for (int k = 0; k < TAPS; k++) rom[0][k] = k + 1;
    send(0, 1000, 5, 0, yv);
    check("overrun_set", longint'(overrun[0]), 1);
    send(0, -77, 0, 0, yv);
    check("overrun_sticky", longint'(overrun[0]), 1);

    // Reset mid-computation aborts; buffer model is cleared too
    send(0, 4321, 0, 6, yv);
    clear_hist();
    send(0, 55, 0, 0, yv);
    check("post_abort_y", yv, 55);

    // Decimation by 4
    for (int k = 0; k < TAPS; k++) rom[1][k] = 1;
    for (int i = 1; i <= 8; i++) begin
      send(1, i, 0, 0, yv);
      if (i == 4) check("decim_y4", yv, 10);
      if (i == 8) check("decim_y8", yv, 36);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
